// File: rtl/uart_tx_mmio_rv_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register word offsets, STATUS bit positions and serializer state encoding.
package uart_tx_mmio_rv_pkg;

  // Word offsets within the 16-byte register window (address bits [3:2])
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  // STATUS bit positions
  localparam int unsigned STAT_FULL      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_BUSY      = 2;
  localparam int unsigned STAT_OVERRUN   = 3;
  localparam int unsigned STAT_COUNT_LSB = 4;
  localparam int unsigned STAT_COUNT_W   = 4;

  localparam int unsigned DIV_W = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_rv_fifo_sync.sv
// Synchronous FIFO with occupancy count.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data (head,
// valid while !empty), full, empty, count (0..2**DEPTH_LOG2).
// Push while full and pop while empty are ignored internally.
module fifo_sync #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array carries no reset; only the pointers and count define state
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio_rv.sv
// Memory-mapped 8N1 UART transmitter on the core's data write / read-2 ports.
// Ports: iwClk, iwRst (sync, active-high); iwWriteAddr/iwWriteData/iwWstrb
// store port; iwReadAddr with combinational owReadData/owReadHit;
// owTx registered serial line, idle high.
module uart_tx_mmio_rv
  import uart_tx_mmio_rv_pkg::*;
#(
  parameter logic [31:0] BASE            = 32'h1000_0000,
  parameter logic [15:0] DEFAULT_DIV     = 16'd867,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic [31:0] iwWriteAddr,
  input  logic [31:0] iwWriteData,
  input  logic [3:0]  iwWstrb,
  input  logic [31:0] iwReadAddr,
  output logic [31:0] owReadData,
  output logic        owReadHit,
  output logic        owTx
);

  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;

  tx_state_e        state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             overrun;

  logic             wr_hit;
  logic [1:0]       wr_off;
  logic             txdata_wr;
  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      status_word;
  logic             unused_bits;

  // Write decode
  assign wr_hit    = (iwWriteAddr[31:4] == BASE[31:4]);
  assign wr_off    = iwWriteAddr[3:2];
  assign txdata_wr = wr_hit && (wr_off == REG_TXDATA) && iwWstrb[0];
  assign fifo_push = txdata_wr && !fifo_full;
  // Head is popped on the IDLE cycle that launches a frame
  assign fifo_pop  = (state == TX_IDLE) && !fifo_empty;

  fifo_sync #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (iwClk),
    .rst       (iwRst),
    .push      (fifo_push),
    .push_data (iwWriteData[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Control registers: sticky OVERRUN and byte-writable divisor
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      overrun <= 1'b0;
      div     <= DEFAULT_DIV;
    end else begin
      // Full is judged at the start of the cycle, so a same-cycle pop does not save the byte
      if (txdata_wr && fifo_full) begin
        overrun <= 1'b1;
      end else if (wr_hit && (wr_off == REG_STATUS) && iwWstrb[0] && iwWriteData[STAT_OVERRUN]) begin
        overrun <= 1'b0;
      end
      if (wr_hit && (wr_off == REG_DIV)) begin
        if (iwWstrb[0]) div[7:0]  <= iwWriteData[7:0];
        if (iwWstrb[1]) div[15:8] <= iwWriteData[15:8];
      end
    end
  end

  // Serializer; the baud counter reloads from the live divisor at each bit boundary
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      state    <= TX_IDLE;
      owTx     <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          owTx <= 1'b1;
          if (!fifo_empty) begin
            shift    <= fifo_head;
            baud_cnt <= div;
            owTx     <= 1'b0;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= div;
            bit_idx  <= '0;
            owTx     <= shift[0];
            state    <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        TX_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= div;
            if (bit_idx == 3'd7) begin
              owTx  <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              owTx    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        TX_STOP: begin
          if (baud_cnt == '0) begin
            owTx  <= 1'b1;
            state <= TX_IDLE;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        default: begin
          owTx  <= 1'b1;
          state <= TX_IDLE;
        end
      endcase
    end
  end

  // STATUS image
  always_comb begin
    status_word = '0;
    status_word[STAT_FULL]    = fifo_full;
    status_word[STAT_EMPTY]   = fifo_empty;
    status_word[STAT_BUSY]    = (state != TX_IDLE);
    status_word[STAT_OVERRUN] = overrun;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
  end

  // Same-cycle load path
  assign owReadHit = (iwReadAddr[31:4] == BASE[31:4]);

  always_comb begin
    owReadData = '0;
    if (owReadHit) begin
      case (iwReadAddr[3:2])
        REG_STATUS: owReadData = status_word;
        REG_DIV:    owReadData = {16'h0000, div};
        default:    owReadData = '0;
      endcase
    end
  end

  assign unused_bits = ^{iwWriteAddr[1:0], iwWriteData[31:16], iwWstrb[3:2], iwReadAddr[1:0]};

endmodule
